// File: rtl/pfb_stall_mon_pkg.sv
// Shared definitions for the PFB dataflow stall monitor.
//   state_e       : monitor FSM states
//   *_DEF         : default channel counts / counter width for the kernel
package pfb_stall_mon_pkg;
  localparam int N_AXIS_DEF    = 12;
  localparam int N_INST_DEF    = 16;
  localparam int TIMEOUT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_COUNT    = 2'd1,
    S_DEADLOCK = 2'd2,
    S_EXT      = 2'd3
  } state_e;
endpackage

// File: rtl/pfb_prio_enc.sv
// Lowest-set-bit priority encoder.
//   vec_i : input vector
//   idx_o : index of the lowest set bit (0 when vec_i is all zero)
module pfb_prio_enc #(
  parameter int W     = 16,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o
);
  // Scan high to low so the last hit (lowest index) wins.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end
endmodule

// File: rtl/pfb_stall_monitor.sv
// Stall / deadlock monitor for the PFB dataflow kernel.
// Watches per-instance idle/block flags and per-port AXIS block flags; once a
// stall persists for T = timeout_i cycles (0 treated as 1) it declares either a
// sticky internal deadlock (no AXIS port blocked) or a self-clearing external
// stall (some AXIS port blocked).
// Ports:
//   ap_clk, ap_rst_n        : clock, async active-low reset
//   axis_block_i/inst_*_i   : stall flags
//   timeout_i, clear_i      : threshold, synchronous clear
//   deadlock_o, ext_stall_o : verdicts; verdict_pulse_o one cycle on entry
//   inst_snap_o/axis_snap_o : flags captured at verdict; first_idx_o lowest
//                             blocked instance in the snapshot
//   stall_cnt_o             : consecutive stall cycle counter (saturating)
//   event_cnt_o             : verdict entries, built only when
//                             PFB_STALL_MON_EVENT_CNT_EN is defined, else 0
module pfb_stall_monitor
  import pfb_stall_mon_pkg::*;
#(
  parameter int N_AXIS    = N_AXIS_DEF,
  parameter int N_INST    = N_INST_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF,
  parameter int IDX_W     = $clog2(N_INST)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [N_AXIS-1:0]    axis_block_i,
  input  logic [N_INST-1:0]    inst_idle_i,
  input  logic [N_INST-1:0]    inst_block_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 clear_i,
  output logic                 deadlock_o,
  output logic                 ext_stall_o,
  output logic                 verdict_pulse_o,
  output logic [N_INST-1:0]    inst_snap_o,
  output logic [N_AXIS-1:0]    axis_snap_o,
  output logic [IDX_W-1:0]     first_idx_o,
  output logic [TIMEOUT_W-1:0] stall_cnt_o,
  output logic [15:0]          event_cnt_o
);
  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc, thr_m1;
  logic [N_INST-1:0]    isnap_q, isnap_d;
  logic [N_AXIS-1:0]    asnap_q, asnap_d;
  logic [IDX_W-1:0]     fidx_q, fidx_d, enc_idx;
  logic                 pulse_q, pulse_d, dl_q, dl_d, ext_q, ext_d;
  logic                 stall, internal, capture;

  // Stalled: everyone is idle or blocked, at least one is blocked, and not
  // simply "all idle" (which is a finished kernel, not a stall).
  assign stall    = (&(inst_idle_i | inst_block_i)) & (|inst_block_i) & ~(&inst_idle_i);
  assign internal = stall & ~(|axis_block_i);

  assign thr_m1  = (timeout_i == '0) ? '0 : timeout_i - TIMEOUT_W'(1);
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_W'(1);

  pfb_prio_enc #(.W(N_INST), .IDX_W(IDX_W)) u_enc (
    .vec_i (inst_block_i),
    .idx_o (enc_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isnap_d = isnap_q;
    asnap_d = asnap_q;
    fidx_d  = fidx_q;
    pulse_d = 1'b0;
    capture = 1'b0;
    case (state_q)
      // cnt_q is always 0 in S_RUN, so T<=1 gives a verdict on the first
      // stalled edge. The >= compare handles timeout_i shrinking mid-count.
      S_RUN, S_COUNT: begin
        if (stall) begin
          cnt_d = cnt_inc;
          if (cnt_q >= thr_m1) begin
            state_d = internal ? S_DEADLOCK : S_EXT;
            capture = 1'b1;
          end else begin
            state_d = S_COUNT;
          end
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_EXT: begin
        if (!stall) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else if (internal) begin
          // Back-pressure went away but the kernel is still stuck: escalate.
          state_d = S_DEADLOCK;
          capture = 1'b1;
        end
      end
      default: ; // S_DEADLOCK: sticky until clear
    endcase
    if (capture) begin
      isnap_d = inst_block_i;
      asnap_d = axis_block_i;
      fidx_d  = enc_idx;
      pulse_d = 1'b1;
    end
    if (clear_i) begin
      state_d = S_RUN;
      cnt_d   = '0;
      isnap_d = '0;
      asnap_d = '0;
      fidx_d  = '0;
      pulse_d = 1'b0;
      capture = 1'b0;
    end
    dl_d  = (state_d == S_DEADLOCK);
    ext_d = (state_d == S_EXT);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      isnap_q <= '0;
      asnap_q <= '0;
      fidx_q  <= '0;
      pulse_q <= 1'b0;
      dl_q    <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isnap_q <= isnap_d;
      asnap_q <= asnap_d;
      fidx_q  <= fidx_d;
      pulse_q <= pulse_d;
      dl_q    <= dl_d;
      ext_q   <= ext_d;
    end
  end

`ifdef PFB_STALL_MON_EVENT_CNT_EN
  logic [15:0] evt_q, evt_d;

  always_comb begin
    evt_d = evt_q;
    if (clear_i)                           evt_d = '0;
    else if (capture && evt_q != 16'hFFFF) evt_d = evt_q + 16'd1;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) evt_q <= '0;
    else           evt_q <= evt_d;
  end

  assign event_cnt_o = evt_q;
`else
  assign event_cnt_o = '0;
`endif

  assign deadlock_o      = dl_q;
  assign ext_stall_o     = ext_q;
  assign verdict_pulse_o = pulse_q;
  assign inst_snap_o     = isnap_q;
  assign axis_snap_o     = asnap_q;
  assign first_idx_o     = fidx_q;
  assign stall_cnt_o     = cnt_q;
endmodule

// File: tb/tb_pfb_stall_monitor.sv
// Scoreboard bench for pfb_stall_monitor: the driver applies inputs on the
// falling edge and pushes the reference model's expected outputs; a monitor
// pops and compares after every rising edge.
module tb_pfb_stall_monitor;
  localparam int NA = 12, NI = 16, TW = 16, IW = 4;

  typedef struct packed {
    logic          dl;
    logic          ext;
    logic          pulse;
    logic [NI-1:0] isnap;
    logic [NA-1:0] asnap;
    logic [IW-1:0] fidx;
    logic [TW-1:0] cnt;
    logic [15:0]   evt;
  } out_t;

  logic          ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic [NA-1:0] axis_block_i = '0;
  logic [NI-1:0] inst_idle_i  = '1, inst_block_i = '0;
  logic [TW-1:0] timeout_i    = 16'd4;
  logic          clear_i      = 1'b0;
  logic          deadlock_o, ext_stall_o, verdict_pulse_o;
  logic [NI-1:0] inst_snap_o;
  logic [NA-1:0] axis_snap_o;
  logic [IW-1:0] first_idx_o;
  logic [TW-1:0] stall_cnt_o;
  logic [15:0]   event_cnt_o;

  pfb_stall_monitor #(.N_AXIS(NA), .N_INST(NI), .TIMEOUT_W(TW), .IDX_W(IW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .axis_block_i(axis_block_i),
    .inst_idle_i(inst_idle_i), .inst_block_i(inst_block_i), .timeout_i(timeout_i),
    .clear_i(clear_i), .deadlock_o(deadlock_o), .ext_stall_o(ext_stall_o),
    .verdict_pulse_o(verdict_pulse_o), .inst_snap_o(inst_snap_o),
    .axis_snap_o(axis_snap_o), .first_idx_o(first_idx_o),
    .stall_cnt_o(stall_cnt_o), .event_cnt_o(event_cnt_o)
  );

  initial forever #5 ap_clk = ~ap_clk;

  int   checks = 0, errors = 0;
  out_t exp_q[$];

  // Reference model: verdict kind plus the length of the current unbroken
  // run of stalled edges.
  int            m_verdict = 0; // 0 none, 1 deadlock, 2 external
  int            m_run     = 0;
  logic          m_pulse   = 1'b0;
  logic [NI-1:0] m_isnap   = '0;
  logic [NA-1:0] m_asnap   = '0;
  logic [IW-1:0] m_fidx    = '0;
  int            m_evt     = 0;

  function automatic out_t act_out();
    out_t o;
    o.dl = deadlock_o; o.ext = ext_stall_o; o.pulse = verdict_pulse_o;
    o.isnap = inst_snap_o; o.asnap = axis_snap_o; o.fidx = first_idx_o;
    o.cnt = stall_cnt_o; o.evt = event_cnt_o;
    return o;
  endfunction

  function automatic out_t mdl_out();
    out_t o;
    o.dl = (m_verdict == 1); o.ext = (m_verdict == 2); o.pulse = m_pulse;
    o.isnap = m_isnap; o.asnap = m_asnap; o.fidx = m_fidx;
    o.cnt = TW'(m_run); o.evt = 16'(m_evt);
    return o;
  endfunction

  task automatic chk(input string n, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got dl=%0b ext=%0b pls=%0b isnap=%h asnap=%h fidx=%0d cnt=%0d evt=%0d, want dl=%0b ext=%0b pls=%0b isnap=%h asnap=%h fidx=%0d cnt=%0d evt=%0d",
               n, a.dl, a.ext, a.pulse, a.isnap, a.asnap, a.fidx, a.cnt, a.evt,
               e.dl, e.ext, e.pulse, e.isnap, e.asnap, e.fidx, e.cnt, e.evt);
    end
  endtask

  task automatic chk_val(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endtask

  task automatic model_reset();
    m_verdict = 0; m_run = 0; m_pulse = 1'b0;
    m_isnap = '0; m_asnap = '0; m_fidx = '0; m_evt = 0;
  endtask

  // One rising edge of the reference model with the currently driven inputs.
  task automatic model_step();
    bit stall, internal, take;
    int thr;
    stall    = (&(inst_idle_i | inst_block_i)) && (|inst_block_i) && !(&inst_idle_i);
    internal = stall && (axis_block_i == '0);
    thr      = (timeout_i == 0) ? 1 : int'(timeout_i);
    take     = 1'b0;
    m_pulse  = 1'b0;
    if (clear_i) begin
      model_reset();
    end else if (m_verdict == 2) begin
      if (!stall) begin m_verdict = 0; m_run = 0; end
      else if (internal) begin m_verdict = 1; take = 1'b1; end
    end else if (m_verdict == 0) begin
      if (stall) begin
        // This edge makes the run (m_run + 1) stalled edges long.
        if (m_run + 1 >= thr) begin m_verdict = internal ? 1 : 2; take = 1'b1; end
        if (m_run < 65535) m_run++;
      end else begin
        m_run = 0;
      end
    end
    if (take) begin
      m_isnap = inst_block_i;
      m_asnap = axis_block_i;
      m_pulse = 1'b1;
      m_fidx  = '0;
      for (int i = 0; i < NI; i++) if (inst_block_i[i]) begin m_fidx = IW'(i); break; end
`ifdef PFB_STALL_MON_EVENT_CNT_EN
      if (m_evt < 65535) m_evt++;
`endif
    end
  endtask

  task automatic cyc(input logic [NI-1:0] blk, input logic [NI-1:0] idl,
                     input logic [NA-1:0] ax, input logic [TW-1:0] to, input logic clr);
    @(negedge ap_clk);
    inst_block_i = blk; inst_idle_i = idl; axis_block_i = ax;
    timeout_i = to; clear_i = clr;
    model_step();
    exp_q.push_back(mdl_out());
  endtask

  task automatic settle();
    @(posedge ap_clk); #2;
  endtask

  // Monitor: compare every presented result against the scoreboard.
  initial forever begin
    @(posedge ap_clk); #1;
    if (exp_q.size() > 0) chk("scoreboard", act_out(), exp_q.pop_front());
  end

  initial begin
    logic [NI-1:0] blk, idl;
    logic [NA-1:0] ax;
    logic [TW-1:0] to;
    int mode, hold;

    #2;
    chk("reset_state", act_out(), '0);
    @(negedge ap_clk); ap_rst_n = 1'b1;

    // Internal deadlock on instance 2, T=4.
    repeat (4) cyc(16'h0004, 16'hFFFB, '0, 16'd4, 1'b0);
    settle();
    chk_val("dl_after_T", deadlock_o, 1);
    chk_val("dl_pulse", verdict_pulse_o, 1);
    chk_val("dl_first_idx", first_idx_o, 2);
    chk_val("dl_inst_snap", inst_snap_o, 16'h0004);
    cyc('0, '1, '0, 16'd4, 1'b0);
    settle();
    chk_val("dl_sticky", deadlock_o, 1);
    chk_val("pulse_one_cycle", verdict_pulse_o, 0);
    cyc('0, '1, '0, 16'd4, 1'b1);
    settle();
    chk("clear_all_zero", act_out(), '0);

    // 3 stalls, gap, 3 stalls: no verdict at T=4.
    repeat (3) cyc(16'h0010, 16'hFFEF, '0, 16'd4, 1'b0);
    cyc('0, '1, '0, 16'd4, 1'b0);
    settle();
    chk_val("gap_cnt_zero", stall_cnt_o, 0);
    repeat (3) cyc(16'h0010, 16'hFFEF, '0, 16'd4, 1'b0);
    settle();
    chk_val("gap_no_verdict", deadlock_o, 0);
    cyc('0, '1, '0, 16'd4, 1'b0);

    // External stall, T=2, then self-clear.
    repeat (2) cyc(16'h0004, 16'hFFFB, 12'h100, 16'd2, 1'b0);
    settle();
    chk_val("ext_set", ext_stall_o, 1);
    chk_val("ext_axis_snap", axis_snap_o, 12'h100);
    cyc('0, '1, '0, 16'd2, 1'b0);
    settle();
    chk_val("ext_cleared", ext_stall_o, 0);
    chk_val("ext_no_dl", deadlock_o, 0);

    // Clear on the verdict edge wins.
    cyc(16'h0001, 16'hFFFE, '0, 16'd2, 1'b0);
    cyc(16'h0001, 16'hFFFE, '0, 16'd2, 1'b1);
    settle();
    chk_val("clr_vs_verdict_dl", deadlock_o, 0);
    chk_val("clr_vs_verdict_evt", event_cnt_o, 0);

    // timeout 0 acts as 1.
    cyc(16'h8000, 16'h7FFF, '0, 16'd0, 1'b0);
    settle();
    chk_val("t0_verdict", deadlock_o, 1);
    chk_val("t0_first_idx", first_idx_o, 15);
    cyc('0, '1, '0, 16'd0, 1'b1);

    // Async reset in the middle of a count.
    repeat (2) cyc(16'h0100, 16'hFEFF, '0, 16'd5, 1'b0);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("async_reset", act_out(), '0);
    model_reset();
    inst_block_i = '0; inst_idle_i = '1; axis_block_i = '0; clear_i = 1'b0;
    @(negedge ap_clk); ap_rst_n = 1'b1;

    // Randomised phase: held modes so stalls persist long enough to matter.
    to = 16'd3; mode = 0; hold = 0; blk = 16'h0001;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        mode = $urandom_range(0, 9);
        hold = $urandom_range(1, 8);
        blk  = 16'($urandom);
        if (blk == '0) blk[$urandom_range(0, NI-1)] = 1'b1;
      end
      hold--;
      if ($urandom_range(0, 49) == 0) to = 16'($urandom_range(0, 6));
      ax = '0;
      if (mode <= 1) begin
        blk = 16'($urandom); idl = 16'($urandom);
        ax  = 12'($urandom);
      end else if (mode <= 5) begin
        idl = ~blk | (16'($urandom) & blk & {16{($urandom_range(0, 7) == 0)}});
        if ($urandom_range(0, 3) == 0) ax = 12'($urandom_range(1, 4095));
      end else if (mode <= 7) begin
        idl = ~blk;
        ax  = 12'($urandom_range(1, 4095));
      end else if (mode == 8) begin
        blk = '0; idl = '1;
      end else begin
        idl = ~blk; idl[$urandom_range(0, NI-1)] = 1'b0;
      end
      cyc(blk, idl, ax, to, ($urandom_range(0, 59) == 0));
    end

    cyc('0, '1, '0, to, 1'b0);
    settle();
    #10;
    chk_val("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
